mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access sequencer for the multicycle CPU. Consumes the byte enables from the
//  byte-enable decoder plus opcode, address and rt store data. Runs one request/ready handshake to data
//  memory, replicates store data across lanes, and returns sign/zero-extended load data.
//  Control FSM pulses start in MEM state and holds there until done.
// PARAMETERS
//  TIMEOUT  16  max REQ cycles waiting for mem_ready before aborting with err (>=2)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle request from control FSM; sampled only in IDLE
//  op         in   6   instruction[31:26]
//  addr       in   32  effective address (ALU result)
//  wdata      in   32  store data (rt)
//  be_in      in   4   byte enables from byte-enable decoder (valid for sb/sh/sw)
//  mem_req    out  1   memory request, held until mem_ready
//  mem_we     out  1   1 = write, 0 = read
//  mem_addr   out  32  word address {addr[31:2],2'b00}
//  mem_be     out  4   lane enables
//  mem_wdata  out  32  lane-replicated store data
//  mem_ready  in   1   memory accepts/completes in the cycle it is high with mem_req
//  mem_rdata  in   32  read word, valid when mem_ready=1
//  rdata      out  32  extended load result, held until next load completes
//  done       out  1   1-cycle completion pulse
//  err        out  1   with done: misaligned, unsupported op or timeout
//  busy       out  1   high in REQ and DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0, timeout counter 0. Reset mid-REQ drops mem_req at once.
//  - Ops: lb 20h, lh 21h, lw 23h, lbu 24h, lhu 25h, sb 28h, sh 29h, sw 2Bh.
//  - States IDLE, REQ, DONE. On start in IDLE, latch op, addr, wdata, be_in.
//  - IDLE + start + legal aligned op -> REQ; mem_req=1; mem_we=1 for stores; bus outputs registered, stable in REQ.
//  - Illegal op, or misalignment (lh/lhu/sh addr[0]=1; lw/sw addr[1:0]!=0) -> DONE, err=1, no bus cycle.
//  - REQ & mem_ready -> DONE; mem_req falls the same edge. Loads capture extended data into rdata.
//  - REQ: counter counts REQ cycles; at TIMEOUT with no ready -> DONE, err=1, mem_req drops, rdata unchanged.
//  - DONE -> IDLE after exactly one cycle; done=1 only in DONE; err valid only with done.
//  - start outside IDLE is ignored; start+reset in same cycle: reset wins.
//  - Latency: start @T0 -> mem_req @T1; ready @Tk -> done @Tk+1 (zero-wait: done @T2).
//  - Stores: mem_be=latched be_in. sb: {4{wdata[7:0]}}; sh: {2{wdata[15:0]}}; sw: wdata.
//  - Loads: mem_be=4'b1111. Byte lane addr[1:0] (00 = bits 7:0); half lane addr[1] (0 = bits 15:0).
//  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes word.
// TESTING
//  sw addr=100h wdata=DEADBEEF, ready in T1 -> mem_we=1 mem_be=1111 mem_wdata=DEADBEEF; done @T2, err=0.
//  sb addr=103h wdata=xxxxxxA5, be_in=1000 -> mem_addr=100h, mem_be=1000, mem_wdata=A5A5A5A5.
//  lb addr=102h, rdata_mem=1280FF34 -> rdata=FFFFFF80; lbu -> 00000080; lh 102h -> 00001280.
//  lw addr=101h -> no mem_req; done @T1 with err=1. op=0Fh -> same.
//  ready held low, TIMEOUT=16 -> mem_req high T1..T16; done+err @T17; rdata unchanged.
//  rst_n low while mem_req=1 -> mem_req=0 immediately; new start after release completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control FSM, the MEM-stage access sequencer and data memory.
// Latency: none, wires only.
// Backpressure: mem_req is held by the sequencer until memory raises mem_ready.
interface mem_access_unit_if;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;

    // Sequencer side
    modport slave (
        input  start, op, addr, wdata, be_in, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, done, err, busy
    );

    // Control FSM plus memory side
    modport master (
        output start, op, addr, wdata, be_in, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, done, err, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access sequencer: one req/ready cycle, store lane replication, load extension.
// Latency: start -> mem_req next cycle; mem_ready -> done next cycle; bad op/alignment -> done+err next cycle.
// Backpressure: mem_req held until mem_ready or TIMEOUT REQ cycles elapse (then done+err).
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_access_unit_if.slave  bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam int         CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_legal;
    logic             w_aligned;
    logic             w_accept;
    logic             w_timeout;
    logic             w_is_store;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_ext;
    logic [31:0]      w_store_dat;

    // Classify the incoming request: known opcode and natural alignment for its access size
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        case (bus.op)
            OP_LB, OP_LBU, OP_SB: begin
                w_legal   = 1'b1;
                w_aligned = 1'b1;
            end
            OP_LH, OP_LHU, OP_SH: begin
                w_legal   = 1'b1;
                w_aligned = ~bus.addr[0];
            end
            OP_LW, OP_SW: begin
                w_legal   = 1'b1;
                w_aligned = (bus.addr[1:0] == 2'b00);
            end
            default: begin
                w_legal   = 1'b0;
                w_aligned = 1'b0;
            end
        endcase
    end

    assign w_accept   = w_legal & w_aligned;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_is_store = r_op[3];

    // State register; reset drops straight to IDLE so mem_req falls without waiting for a clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: bad requests skip the bus, REQ ends on ready or after TIMEOUT cycles
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = w_accept ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ready || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the request on acceptance, track REQ cycles and capture load data / error status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op    <= 6'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_be    <= bus.be_in;
                        r_err   <= ~w_accept;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ready) begin
                        r_cnt <= '0;
                        if (!w_is_store) begin
                            r_rdata <= w_load_ext;
                        end
                    end else if (w_timeout) begin
                        r_cnt <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Pick the addressed byte and halfword lanes out of the returned word
    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_addr[1:0])
            2'b00: w_byte = bus.mem_rdata[7:0];
            2'b01: w_byte = bus.mem_rdata[15:8];
            2'b10: w_byte = bus.mem_rdata[23:16];
            2'b11: w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    // Extend the selected lane according to the load flavour
    always_comb begin
        w_load_ext = bus.mem_rdata;
        case (r_op)
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h0, w_byte};
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = bus.mem_rdata;
        endcase
    end

    // Replicate narrow store data across all lanes so mem_be alone selects the target
    always_comb begin
        w_store_dat = r_wdata;
        case (r_op)
            OP_SB:   w_store_dat = {4{r_wdata[7:0]}};
            OP_SH:   w_store_dat = {2{r_wdata[15:0]}};
            default: w_store_dat = r_wdata;
        endcase
    end

    // Outputs decoded from the state register; bus fields come from latched values and are zero outside REQ
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_be    = 4'h0;
        bus.mem_wdata = 32'h0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.busy      = (r_state != ST_IDLE);
        bus.rdata     = r_rdata;
        if (r_state == ST_REQ) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = w_is_store;
            bus.mem_addr  = {r_addr[31:2], 2'b00};
            bus.mem_be    = w_is_store ? r_be : 4'b1111;
            bus.mem_wdata = w_is_store ? w_store_dat : 32'h0;
        end
        if (r_state == ST_DONE) begin
            bus.done = 1'b1;
            bus.err  = r_err;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases then randomized transactions.
// Latency: checks start->mem_req, ready->done and bad-request->done timing cycle by cycle.
// Backpressure: memory stalls of random length, including no response until timeout.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (access-size arithmetic) ----------------
    function automatic int access_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic bit is_signed_load(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21);
    endfunction

    function automatic bit request_ok(input logic [5:0] op, input logic [31:0] addr);
        int sz;
        sz = access_size(op);
        return (sz != 0) && ((addr % sz) == 0);
    endfunction

    function automatic logic [31:0] store_image(input logic [5:0] op, input logic [31:0] w);
        case (access_size(op))
            1:       return w[7:0] * 32'h0101_0101;
            2:       return w[15:0] * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [5:0] op, input logic [31:0] addr,
                                                input logic [31:0] word);
        longint sz, off, mask, v;
        sz   = access_size(op);
        off  = longint'(addr % 4);
        mask = (longint'(1) << (8 * sz)) - 1;
        v    = (longint'(word) >> (8 * off)) & mask;
        if (is_signed_load(op) && (v > (mask >> 1)))
            v = v - (mask + 1);
        return v[31:0];
    endfunction

    // ---------------- one complete access ----------------
    // ready_cyc: REQ cycle (1..TIMEOUT) in which memory answers; 0 = never answers
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int ready_cyc, input logic [31:0] rd,
                           input bit poke_start);
        bit ok, st, got;
        ok  = request_ok(op, addr);
        st  = is_store(op);
        got = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata; bus.be_in = be;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 6'($urandom); bus.addr = $urandom;
        bus.wdata = $urandom; bus.be_in = 4'($urandom);
        if (!ok) begin
            check("bad_no_req", bus.mem_req, 0);
            check("bad_done",   bus.done,    1);
            check("bad_err",    bus.err,     1);
            check("bad_busy",   bus.busy,    1);
        end else begin
            for (int c = 1; c <= TIMEOUT; c++) begin
                check("req_held", bus.mem_req, 1);
                check("req_nodone", bus.done, 0);
                check("req_we",   bus.mem_we, st);
                check("req_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                check("req_be",   bus.mem_be, st ? be : 4'b1111);
                if (st) check("req_wdata", bus.mem_wdata, store_image(op, wdata));
                got = (c == ready_cyc);
                bus.mem_ready = got;
                bus.mem_rdata = got ? rd : $urandom;
                bus.start     = poke_start && (c == 2);
                @(negedge clk);
                bus.mem_ready = 1'b0;
                bus.start     = 1'b0;
                if (got) break;
            end
            if (got && !st) exp_rdata = load_result(op, addr, rd);
            check("fin_done", bus.done, 1);
            check("fin_err",  bus.err,  !got);
            check("fin_req",  bus.mem_req, 0);
        end
        check("rdata", bus.rdata, exp_rdata);
        @(negedge clk);
        check("idle_done", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_req",  bus.mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops [10];
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0F, 6'h00};
        bus.start = 1'b0; bus.op = 6'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        bus.be_in = 4'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;

        // reset state
        #12;
        check("rst_req",   bus.mem_req, 0);
        check("rst_we",    bus.mem_we, 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_be",    bus.mem_be, 0);
        check("rst_done",  bus.done, 0);
        check("rst_err",   bus.err, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_txn(6'h2B, 32'h100, 32'hDEADBEEF, 4'b1111, 1, 32'h0, 1'b0);
        run_txn(6'h28, 32'h103, 32'h123456A5, 4'b1000, 2, 32'h0, 1'b0);
        run_txn(6'h20, 32'h102, 32'h0, 4'b0000, 1, 32'h1280FF34, 1'b0);
        check("lb_const", bus.rdata, 32'hFFFFFF80);
        run_txn(6'h24, 32'h102, 32'h0, 4'b0000, 3, 32'h1280FF34, 1'b1);
        check("lbu_const", bus.rdata, 32'h00000080);
        run_txn(6'h21, 32'h102, 32'h0, 4'b0000, 1, 32'h1280FF34, 1'b0);
        check("lh_const", bus.rdata, 32'h00001280);
        run_txn(6'h23, 32'h101, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
        run_txn(6'h0F, 32'h100, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
        run_txn(6'h23, 32'h200, 32'h0, 4'b0000, 0, 32'hCAFEF00D, 1'b1);
        check("timeout_keep", bus.rdata, 32'h00001280);
        run_txn(6'h23, 32'h204, 32'h0, 4'b0000, TIMEOUT, 32'h600DF00D, 1'b0);

        // reset in the middle of a bus cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = 6'h23; bus.addr = 32'h300;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_req_up", bus.mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",  bus.mem_req, 0);
        check("mid_rst_busy", bus.busy, 0);
        exp_rdata = 32'h0;
        check("mid_rst_rdata", bus.rdata, exp_rdata);
        // start coinciding with reset is dropped
        bus.start = 1'b1; bus.op = 6'h2B; bus.addr = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        check("rst_start_busy", bus.busy, 0);
        run_txn(6'h25, 32'h302, 32'h0, 4'b0000, 2, 32'h8001_7F00, 1'b0);

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            run_txn(op, a, $urandom, 4'($urandom), $urandom_range(0, TIMEOUT),
                    $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
